// File: rtl/hotcache_assoc.sv
// rtl/hotcache_assoc.sv - fully associative hot-line cache keyed by (base register, offset)
//
// Purpose: small fully associative cache. Lookups are combinational against
// registered state. Fills update an existing entry in place, take the lowest
// free entry, or replace the entry at a round-robin victim pointer. Committing
// a base register invalidates every entry tagged with it. Saturating hit and
// miss counters and a registered occupancy count are provided.
//
// Ports:
//   clk                               rising-edge clock
//   a_rst                             asynchronous active-low reset
//   rd_en, rd_reg, rd_offset          lookup; rd_en only qualifies statistics
//   rd_data, rd_cached                lookup result (data is 0 on a miss)
//   crb_commit, crb_reg               invalidate all entries tagged crb_reg
//   cmd_cache, cmd_reg, cmd_offset,
//   cmd_data                          fill or update request
//   flush                             invalidate everything, pointer to 0
//   hit_count, miss_count             saturating 16-bit lookup statistics
//   occupancy                         number of valid entries
module hotcache_assoc #(
    parameter int DATA_W = 16,
    parameter int OFF_W  = 16,
    parameter int REG_W  = 3,
    parameter int WAYS   = 4
) (
    input  logic                       clk,
    input  logic                       a_rst,
    input  logic                       rd_en,
    input  logic [REG_W-1:0]           rd_reg,
    input  logic [OFF_W-1:0]           rd_offset,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_cached,
    input  logic [REG_W-1:0]           crb_reg,
    input  logic                       crb_commit,
    input  logic                       cmd_cache,
    input  logic [REG_W-1:0]           cmd_reg,
    input  logic [OFF_W-1:0]           cmd_offset,
    input  logic [DATA_W-1:0]          cmd_data,
    input  logic                       flush,
    output logic [15:0]                hit_count,
    output logic [15:0]                miss_count,
    output logic [$clog2(WAYS):0]      occupancy
);

    localparam int IDX_W = $clog2(WAYS);
    localparam int OCC_W = IDX_W + 1;

    logic [WAYS-1:0]   valid_q, valid_d, valid_kept;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [15:0]       hit_count_q, hit_count_d;
    logic [15:0]       miss_count_q, miss_count_d;
    logic [OCC_W-1:0]  occupancy_q, occupancy_d;

    logic [REG_W-1:0]  tag_reg_q [WAYS];
    logic [REG_W-1:0]  tag_reg_d [WAYS];
    logic [OFF_W-1:0]  tag_off_q [WAYS];
    logic [OFF_W-1:0]  tag_off_d [WAYS];
    logic [DATA_W-1:0] data_q    [WAYS];
    logic [DATA_W-1:0] data_d    [WAYS];

    logic              rd_hit;
    logic [DATA_W-1:0] rd_sel;
    logic              fill_hit;
    logic [IDX_W-1:0]  fill_idx;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  wr_idx;

    // Lookup. Tags are unique among valid entries, so OR-ing the data of the
    // matching entries yields the single hit's data, or 0 on a miss.
    always_comb begin
        rd_hit = 1'b0;
        rd_sel = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[i] && tag_reg_q[i] == rd_reg && tag_off_q[i] == rd_offset) begin
                rd_hit = 1'b1;
                rd_sel = rd_sel | data_q[i];
            end
        end
    end

    assign rd_cached  = rd_hit;
    assign rd_data    = rd_sel;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign occupancy  = occupancy_q;

    // Commit is applied before the fill, so the tag search and the free-entry
    // search both operate on the post-commit valid vector.
    always_comb begin
        valid_kept = valid_q;
        for (int i = 0; i < WAYS; i++) begin
            if (crb_commit && tag_reg_q[i] == crb_reg) begin
                valid_kept[i] = 1'b0;
            end
        end

        fill_hit = 1'b0;
        fill_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_kept[i] && tag_reg_q[i] == cmd_reg && tag_off_q[i] == cmd_offset) begin
                fill_hit = 1'b1;
                fill_idx = IDX_W'(i);
            end
        end

        // Scanning downward leaves the lowest free index selected.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_kept[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        if (fill_hit) begin
            wr_idx = fill_idx;
        end else if (free_found) begin
            wr_idx = free_idx;
        end else begin
            wr_idx = ptr_q;
        end
    end

    always_comb begin
        valid_d = valid_kept;
        ptr_d   = ptr_q;
        for (int i = 0; i < WAYS; i++) begin
            tag_reg_d[i] = tag_reg_q[i];
            tag_off_d[i] = tag_off_q[i];
            data_d[i]    = data_q[i];
        end

        if (flush) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (cmd_cache) begin
            valid_d[wr_idx]   = 1'b1;
            tag_reg_d[wr_idx] = cmd_reg;
            tag_off_d[wr_idx] = cmd_offset;
            data_d[wr_idx]    = cmd_data;
            // Only an eviction advances the victim pointer; WAYS is a power
            // of two so the increment wraps naturally.
            if (!fill_hit && !free_found) begin
                ptr_d = ptr_q + IDX_W'(1);
            end
        end

        occupancy_d = '0;
        for (int i = 0; i < WAYS; i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
        end

        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (rd_en) begin
            if (rd_hit) begin
                if (hit_count_q != 16'hFFFF) begin
                    hit_count_d = hit_count_q + 16'd1;
                end
            end else begin
                if (miss_count_q != 16'hFFFF) begin
                    miss_count_d = miss_count_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            valid_q      <= '0;
            ptr_q        <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            occupancy_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            ptr_q        <= ptr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            occupancy_q  <= occupancy_d;
        end
    end

    // Tag and data storage is not reset; nothing observes it while invalid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WAYS; i++) begin
            tag_reg_q[i] <= tag_reg_d[i];
            tag_off_q[i] <= tag_off_d[i];
            data_q[i]    <= data_d[i];
        end
    end

endmodule

// File: tb/tb_hotcache_assoc.sv
// tb/tb_hotcache_assoc.sv - directed self-checking bench for hotcache_assoc
module tb_hotcache_assoc;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        rd_en;
    logic [2:0]  rd_reg;
    logic [15:0] rd_offset;
    logic [15:0] rd_data;
    logic        rd_cached;
    logic [2:0]  crb_reg;
    logic        crb_commit;
    logic        cmd_cache;
    logic [2:0]  cmd_reg;
    logic [15:0] cmd_offset;
    logic [15:0] cmd_data;
    logic        flush;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    hotcache_assoc dut (
        .clk        (clk),
        .a_rst      (a_rst),
        .rd_en      (rd_en),
        .rd_reg     (rd_reg),
        .rd_offset  (rd_offset),
        .rd_data    (rd_data),
        .rd_cached  (rd_cached),
        .crb_reg    (crb_reg),
        .crb_commit (crb_commit),
        .cmd_cache  (cmd_cache),
        .cmd_reg    (cmd_reg),
        .cmd_offset (cmd_offset),
        .cmd_data   (cmd_data),
        .flush      (flush),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_rst      = 1'b0;
        rd_en      = 1'b0;
        rd_reg     = '0;
        rd_offset  = '0;
        crb_reg    = '0;
        crb_commit = 1'b0;
        cmd_cache  = 1'b0;
        cmd_reg    = '0;
        cmd_offset = '0;
        cmd_data   = '0;
        flush      = 1'b0;
        tick();
        tick();
        a_rst = 1'b1;
    endtask

    task automatic fill(input logic [2:0] r, input logic [15:0] o, input logic [15:0] d);
        cmd_cache  = 1'b1;
        cmd_reg    = r;
        cmd_offset = o;
        cmd_data   = d;
        tick();
        cmd_cache  = 1'b0;
    endtask

    // Uncounted lookup; outputs are sampled on the falling edge.
    task automatic look(input logic [2:0] r, input logic [15:0] o);
        rd_en     = 1'b0;
        rd_reg    = r;
        rd_offset = o;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        look(3'd0, 16'h0000);
        checks++;
        if ({rd_cached, rd_data} !== 17'h0) begin
            errors++; $display("FAIL reset_lookup: got %b/%h want 0/0000", rd_cached, rd_data);
        end
        checks++;
        if ({hit_count, miss_count, occupancy} !== 35'h0) begin
            errors++; $display("FAIL reset_stats: got %h/%h/%0d want 0/0/0", hit_count, miss_count, occupancy);
        end
    endtask

    task automatic test_basic();
        do_reset();
        fill(3'd1, 16'h0010, 16'hBEEF);
        rd_en = 1'b1; rd_reg = 3'd1; rd_offset = 16'h0010;
        #1;
        checks++;
        if ({rd_cached, rd_data} !== {1'b1, 16'hBEEF}) begin
            errors++; $display("FAIL basic_hit: got %b/%h want 1/beef", rd_cached, rd_data);
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if ({hit_count, miss_count, occupancy} !== {16'd1, 16'd0, 3'd1}) begin
            errors++; $display("FAIL basic_stats: got %0d/%0d/%0d want 1/0/1", hit_count, miss_count, occupancy);
        end
        // Lookups with rd_en low are never counted.
        look(3'd1, 16'h0010);
        tick();
        checks++;
        if (hit_count !== 16'd1) begin
            errors++; $display("FAIL basic_no_count: got %0d want 1", hit_count);
        end
        // Same tag updates data in place without consuming an entry.
        fill(3'd1, 16'h0010, 16'hCAFE);
        look(3'd1, 16'h0010);
        checks++;
        if ({rd_cached, rd_data, occupancy} !== {1'b1, 16'hCAFE, 3'd1}) begin
            errors++; $display("FAIL basic_update: got %b/%h/%0d want 1/cafe/1", rd_cached, rd_data, occupancy);
        end
        look(3'd0, 16'h0010);
        checks++;
        if ({rd_cached, rd_data} !== 17'h0) begin
            errors++; $display("FAIL basic_other_reg: got %b/%h want 0/0000", rd_cached, rd_data);
        end
    endtask

    task automatic test_replace();
        do_reset();
        for (int t = 1; t <= 5; t++) begin
            fill(3'd0, 16'h0020 + 16'(t), 16'hA000 + 16'(t));
        end
        look(3'd0, 16'h0021);
        checks++;
        if ({rd_cached, rd_data} !== 17'h0) begin
            errors++; $display("FAIL replace_first_gone: got %b/%h want 0/0000", rd_cached, rd_data);
        end
        for (int t = 2; t <= 5; t++) begin
            look(3'd0, 16'h0020 + 16'(t));
            checks++;
            if ({rd_cached, rd_data} !== {1'b1, 16'hA000 + 16'(t)}) begin
                errors++; $display("FAIL replace_hit_%0d: got %b/%h want 1/%h", t, rd_cached, rd_data, 16'hA000 + 16'(t));
            end
        end
        checks++;
        if (occupancy !== 3'd4) begin
            errors++; $display("FAIL replace_occ: got %0d want 4", occupancy);
        end
        // An in-place update must not move the pointer (1): the next new tag
        // then evicts entry 1, which holds tag 2.
        fill(3'd0, 16'h0023, 16'hB003);
        fill(3'd0, 16'h0026, 16'hA006);
        look(3'd0, 16'h0022);
        checks++;
        if (rd_cached !== 1'b0) begin
            errors++; $display("FAIL replace_ptr_victim: got %b want 0", rd_cached);
        end
        look(3'd0, 16'h0023);
        checks++;
        if ({rd_cached, rd_data} !== {1'b1, 16'hB003}) begin
            errors++; $display("FAIL replace_ptr_keep: got %b/%h want 1/b003", rd_cached, rd_data);
        end
        look(3'd0, 16'h0026);
        checks++;
        if ({rd_cached, rd_data} !== {1'b1, 16'hA006}) begin
            errors++; $display("FAIL replace_new: got %b/%h want 1/a006", rd_cached, rd_data);
        end
    endtask

    task automatic test_commit();
        do_reset();
        fill(3'd2, 16'h0000, 16'h2000);
        fill(3'd2, 16'h0001, 16'h2001);
        fill(3'd3, 16'h0000, 16'h3000);
        crb_commit = 1'b1; crb_reg = 3'd2;
        tick();
        crb_commit = 1'b0;
        look(3'd2, 16'h0000);
        checks++;
        if (rd_cached !== 1'b0) begin
            errors++; $display("FAIL commit_r2o0: got %b want 0", rd_cached);
        end
        look(3'd2, 16'h0001);
        checks++;
        if (rd_cached !== 1'b0) begin
            errors++; $display("FAIL commit_r2o1: got %b want 0", rd_cached);
        end
        look(3'd3, 16'h0000);
        checks++;
        if ({rd_cached, rd_data, occupancy} !== {1'b1, 16'h3000, 3'd1}) begin
            errors++; $display("FAIL commit_r3: got %b/%h/%0d want 1/3000/1", rd_cached, rd_data, occupancy);
        end
    endtask

    task automatic test_commit_fill();
        do_reset();
        fill(3'd2, 16'h0000, 16'h2000);
        fill(3'd2, 16'h0001, 16'h2001);
        fill(3'd3, 16'h0000, 16'h3000);
        crb_commit = 1'b1; crb_reg = 3'd2;
        fill(3'd2, 16'h0004, 16'h1234);
        crb_commit = 1'b0;
        look(3'd2, 16'h0004);
        checks++;
        if ({rd_cached, rd_data, occupancy} !== {1'b1, 16'h1234, 3'd2}) begin
            errors++; $display("FAIL cfill_new: got %b/%h/%0d want 1/1234/2", rd_cached, rd_data, occupancy);
        end
        look(3'd2, 16'h0000);
        checks++;
        if (rd_cached !== 1'b0) begin
            errors++; $display("FAIL cfill_old0: got %b want 0", rd_cached);
        end
        look(3'd2, 16'h0001);
        checks++;
        if (rd_cached !== 1'b0) begin
            errors++; $display("FAIL cfill_old1: got %b want 0", rd_cached);
        end
        // Refill the same tag while committing its register: entry must stay valid.
        crb_commit = 1'b1; crb_reg = 3'd2;
        fill(3'd2, 16'h0004, 16'h5678);
        crb_commit = 1'b0;
        look(3'd2, 16'h0004);
        checks++;
        if ({rd_cached, rd_data, occupancy} !== {1'b1, 16'h5678, 3'd2}) begin
            errors++; $display("FAIL cfill_same: got %b/%h/%0d want 1/5678/2", rd_cached, rd_data, occupancy);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int t = 1; t <= 5; t++) begin
            fill(3'd0, 16'(t), 16'h0100 + 16'(t));
        end
        rd_en = 1'b1; rd_reg = 3'd0; rd_offset = 16'd2;
        tick();
        rd_offset = 16'd1;
        tick();
        rd_en = 1'b0;
        flush = 1'b1; crb_commit = 1'b1; crb_reg = 3'd0;
        fill(3'd0, 16'd9, 16'h0109);
        flush = 1'b0; crb_commit = 1'b0;
        look(3'd0, 16'd2);
        checks++;
        if ({rd_cached, occupancy} !== 4'h0) begin
            errors++; $display("FAIL flush_empty: got %b/%0d want 0/0", rd_cached, occupancy);
        end
        look(3'd0, 16'd9);
        checks++;
        if (rd_cached !== 1'b0) begin
            errors++; $display("FAIL flush_fill_ignored: got %b want 0", rd_cached);
        end
        checks++;
        if ({hit_count, miss_count} !== {16'd1, 16'd1}) begin
            errors++; $display("FAIL flush_counters: got %0d/%0d want 1/1", hit_count, miss_count);
        end
        // Pointer back at 0: the fifth new tag must evict entry 0 (offset 11).
        for (int t = 11; t <= 15; t++) begin
            fill(3'd0, 16'(t), 16'h0100 + 16'(t));
        end
        look(3'd0, 16'd11);
        checks++;
        if (rd_cached !== 1'b0) begin
            errors++; $display("FAIL flush_ptr_evict: got %b want 0", rd_cached);
        end
        look(3'd0, 16'd12);
        checks++;
        if ({rd_cached, rd_data, occupancy} !== {1'b1, 16'h010C, 3'd4}) begin
            errors++; $display("FAIL flush_ptr_keep: got %b/%h/%0d want 1/010c/4", rd_cached, rd_data, occupancy);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        rd_en = 1'b1; rd_reg = 3'd7; rd_offset = 16'h7777;
        repeat (16'hFFFE) @(posedge clk);
        #1;
        checks++;
        if (miss_count !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre: got %h want fffe", miss_count);
        end
        repeat (4) @(posedge clk);
        #1;
        rd_en = 1'b0;
        checks++;
        if ({miss_count, hit_count} !== {16'hFFFF, 16'h0}) begin
            errors++; $display("FAIL sat_hold: got %h/%h want ffff/0000", miss_count, hit_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(3'd1, 16'h0010, 16'hBEEF);
        rd_en = 1'b1; rd_reg = 3'd1; rd_offset = 16'h0010;
        tick();
        rd_offset = 16'h0011;
        tick();
        rd_offset = 16'h0010;
        // Fill presented, then reset drops in the middle of the cycle.
        cmd_cache = 1'b1; cmd_reg = 3'd5; cmd_offset = 16'h0055; cmd_data = 16'h5555;
        #2;
        a_rst = 1'b0;
        #1;
        checks++;
        if ({rd_cached, rd_data, hit_count, miss_count, occupancy} !== 52'h0) begin
            errors++; $display("FAIL rstmid_outputs: got %b/%h/%h/%h/%0d want all 0", rd_cached, rd_data, hit_count, miss_count, occupancy);
        end
        tick();
        rd_en = 1'b0; cmd_cache = 1'b0;
        a_rst = 1'b1;
        look(3'd5, 16'h0055);
        checks++;
        if ({rd_cached, occupancy} !== 4'h0) begin
            errors++; $display("FAIL rstmid_fill_dropped: got %b/%0d want 0/0", rd_cached, occupancy);
        end
        tick();
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        fill(3'd6, 16'h0066, 16'h6666);
        look(3'd6, 16'h0066);
        checks++;
        if ({rd_cached, rd_data, occupancy} !== {1'b1, 16'h6666, 3'd1}) begin
            errors++; $display("FAIL rstmid_first_edge: got %b/%h/%0d want 1/6666/1", rd_cached, rd_data, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replace();
        test_commit();
        test_commit_fill();
        test_flush();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
